// File: rtl/bp_pkg.sv
// Shared types and helpers for the branch target predictor: BTB entry layout,
// 2-bit saturating counter arithmetic and PC -> index/tag field extraction.
package bp_pkg;

  localparam int BP_IDX_BITS = 4;
  localparam int BP_PC_W     = 16;
  localparam int TAG_W       = BP_PC_W - BP_IDX_BITS - 1;
  localparam int CTR_W       = 2;

  localparam logic [CTR_W-1:0] CTR_RESET = 2'b01;
  localparam logic [CTR_W-1:0] CTR_ALLOC = 2'b10;

  typedef struct packed {
    logic               valid;
    logic [TAG_W-1:0]   tag;
    logic [BP_PC_W-1:0] target;
    logic [CTR_W-1:0]   ctr;
  } btb_entry_t;

  function automatic logic [CTR_W-1:0] sat_inc(input logic [CTR_W-1:0] c);
    return (c == '1) ? c : c + 1'b1;
  endfunction

  function automatic logic [CTR_W-1:0] sat_dec(input logic [CTR_W-1:0] c);
    return (c == '0) ? c : c - 1'b1;
  endfunction

  // PCs are halfword aligned, so callers pass pc[PC_W-1:1] and bit 0 never enters the BTB.
  function automatic logic [BP_IDX_BITS-1:0] btb_idx(input logic [BP_PC_W-1:1] hw);
    return hw[BP_IDX_BITS:1];
  endfunction

  function automatic logic [TAG_W-1:0] btb_tag(input logic [BP_PC_W-1:1] hw);
    return hw[BP_PC_W-1:BP_IDX_BITS+1];
  endfunction

endpackage

// File: rtl/sat_counter_update.sv
// Next value of a 2-bit saturating direction counter given the resolved
// branch outcome (taken counts up, not-taken counts down).
module sat_counter_update
  import bp_pkg::*;
(
  input  logic [CTR_W-1:0] i_ctr,
  input  logic             i_jump,
  output logic [CTR_W-1:0] o_ctr
);

  assign o_ctr = i_jump ? sat_inc(i_ctr) : sat_dec(i_ctr);

endmodule

// File: rtl/branch_target_predictor.sv
// Direct-mapped BTB predictor: zero-latency lookup on the fetch PC, trained
// from the execute stage using PCs tracked through valid-gated pipeline flops.
module branch_target_predictor #(
  parameter int                       IDX_BITS  = bp_pkg::BP_IDX_BITS,
  parameter int                       PC_W      = bp_pkg::BP_PC_W,
  parameter logic [bp_pkg::CTR_W-1:0] CTR_RESET = bp_pkg::CTR_RESET,
  parameter logic [bp_pkg::CTR_W-1:0] CTR_ALLOC = bp_pkg::CTR_ALLOC
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            valid_fetch,
  input  logic            valid_rf_read,
  input  logic            valid_execute,
  input  logic [PC_W-1:0] current_pc,
  input  logic            is_pc_jump,
  input  logic            jump,
  input  logic [PC_W-1:0] target_pc,
  output logic            prediction,
  output logic [PC_W-1:0] prediction_pc
);

  import bp_pkg::*;

  localparam int N_ENT = 1 << IDX_BITS;

  btb_entry_t r_btb [N_ENT];

  logic [PC_W-1:1] r_pc_rf;
  logic [PC_W-1:1] r_pc_ex;
  logic            r_br_ex;

  logic [IDX_BITS-1:0] w_lk_idx;
  logic [IDX_BITS-1:0] w_up_idx;
  btb_entry_t          w_lk;
  btb_entry_t          w_up;
  logic                w_lk_hit;
  logic                w_up_hit;
  logic                w_up_en;
  logic [CTR_W-1:0]    w_up_ctr;

  // Lookup reads the registered array directly, so a same-cycle update is not bypassed.
  assign w_lk_idx      = btb_idx(current_pc[PC_W-1:1]);
  assign w_lk          = r_btb[w_lk_idx];
  assign w_lk_hit      = w_lk.valid && (w_lk.tag == btb_tag(current_pc[PC_W-1:1]));
  assign prediction    = w_lk_hit && w_lk.ctr[1];
  assign prediction_pc = prediction ? w_lk.target : current_pc + PC_W'(2);

  assign w_up_idx = btb_idx(r_pc_ex);
  assign w_up     = r_btb[w_up_idx];
  assign w_up_hit = w_up.valid && (w_up.tag == btb_tag(r_pc_ex));
  assign w_up_en  = valid_execute && r_br_ex;

  sat_counter_update u_ctr_upd (
    .i_ctr  (w_up.ctr),
    .i_jump (jump),
    .o_ctr  (w_up_ctr)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_pc_rf <= '0;
      r_pc_ex <= '0;
      r_br_ex <= 1'b0;
    end else begin
      if (valid_fetch) begin
        r_pc_rf <= current_pc[PC_W-1:1];
      end
      if (valid_rf_read) begin
        r_pc_ex <= r_pc_rf;
        r_br_ex <= is_pc_jump;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < N_ENT; i++) begin
        r_btb[i] <= '{valid: 1'b0, tag: '0, target: '0, ctr: CTR_RESET};
      end
    end else if (w_up_en) begin
      if (w_up_hit) begin
        r_btb[w_up_idx].ctr <= w_up_ctr;
        if (jump) begin
          r_btb[w_up_idx].target <= target_pc;
        end
      end else if (jump) begin
        // Taken miss evicts whatever alias currently owns the slot.
        r_btb[w_up_idx] <= '{valid: 1'b1, tag: btb_tag(r_pc_ex), target: target_pc, ctr: CTR_ALLOC};
      end
    end
  end

endmodule

// File: doc/branch_target_predictor.md
Name: branch_target_predictor

Overview:
- Responder side of the PC controller's prediction interface.
- Receives the fetch-stage PC every cycle and answers combinationally with a taken/not-taken prediction and a next-PC.
- Learns from branch outcomes resolved in the execute stage, through a direct-mapped branch target buffer (BTB) with 2-bit saturating counters.
- Sits beside the PC controller in the fetch / rf_read / execute pipeline.

Parameters:
- IDX_BITS, 4, log2 of BTB entries (16 entries); index = pc[IDX_BITS:1].
- PC_W, 16, PC and target width.
- CTR_RESET, 2'b01, counter value after reset (weakly not-taken).
- CTR_ALLOC, 2'b10, counter value on allocation (weakly taken).

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low (asserted when 0); clears all state.
- valid_fetch  in  1  fetch stage holds a valid instruction; gates the fetch->rf_read PC capture.
- valid_rf_read  in  1  rf_read stage valid; gates the rf_read->execute capture.
- valid_execute  in  1  execute stage valid; gates BTB update.
- current_pc  in  PC_W  fetch-stage PC.
- is_pc_jump  in  1  instruction in rf_read is J/JN/JZ/CALL (any form).
- jump  in  1  execute-stage resolved outcome (1 = taken).
- target_pc  in  PC_W  execute-stage resolved next PC (the taken target when jump=1).
- prediction  out  1  predicted taken for current_pc.
- prediction_pc  out  PC_W  predicted next PC.

Behaviour:
- Storage, per entry: valid(1), tag(PC_W-IDX_BITS-1 = pc[15:IDX_BITS+1]), target(PC_W), ctr(2). pc[0] is ignored (always 0).
- Lookup is combinational, with zero cycles of latency:
  - hit = valid[idx] && tag[idx]==current_pc tag field.
  - prediction = hit && ctr[idx][1].
  - prediction_pc = prediction ? target[idx] : current_pc+2, with 16-bit wrap (0xFFFE -> 0x0000).
- Pipeline tracking registers:
  - pc_rf: captures current_pc at a clk edge when valid_fetch=1; otherwise holds.
  - pc_ex and br_ex: capture pc_rf and is_pc_jump at an edge when valid_rf_read=1; otherwise hold.
- Update occurs at a clk edge when valid_execute && br_ex, indexed by pc_ex:
  - Hit, jump=1: ctr <= sat_inc(ctr) (max 2'b11); target <= target_pc.
  - Hit, jump=0: ctr <= sat_dec(ctr) (min 2'b00); target unchanged.
  - Miss, jump=1: allocate, overwriting any victim: valid<=1, tag<=pc_ex tag, target<=target_pc, ctr<=CTR_ALLOC.
  - Miss, jump=0: no change.
- No update when valid_execute=0 or br_ex=0, including squashed instructions.
- Simultaneous lookup and update of the same index: the lookup sees pre-update contents (no bypass). The new value is visible the following cycle.
- Reset, asynchronous assert with synchronous deassert handled upstream:
  - All valid bits cleared; ctr <= CTR_RESET; tag and target <= 0.
  - pc_rf and pc_ex <= 0; br_ex <= 0.
  - Outputs during and after reset are therefore prediction=0 and prediction_pc=current_pc+2.
- Reset asserted mid-update: the update is lost and all state is cleared.
- Stall interaction: because of the valid gating, a held stage keeps its PC, so a later update is attributed to the correct branch.
- The predictor never flushes itself. Squash is expressed only via the valid inputs from the PC controller.

Decomposition:
- Shared package (bp_pkg):
  - btb_entry_t struct {valid, tag, target, ctr}.
  - CTR_W=2, CTR_RESET, CTR_ALLOC.
  - Functions sat_inc/sat_dec and btb_idx/btb_tag extraction.
- One natural sub-module, sat_counter_update: combinational next-counter given ctr and jump. Instantiated once on the update path.
- The BTB is a flop array (async reset required), not inferred RAM.

Test Plan:
- Reset then current_pc=0x0040 -> prediction=0, prediction_pc=0x0042; current_pc=0xFFFE -> prediction_pc=0x0000.
- Branch at 0x0040, taken to 0x0100, resolved once (valid_fetch, valid_rf_read and valid_execute pulsed in order, is_pc_jump=1, jump=1) -> next lookup of 0x0040 gives prediction=1, prediction_pc=0x0100 (ctr=10).
- Same branch resolved not-taken once -> ctr=01, prediction=0, prediction_pc=0x0042; three taken outcomes -> ctr saturates at 11; two not-taken -> ctr=01 and prediction=0.
- Alias: train 0x0040 taken, then resolve 0x0060 (same idx, different tag) taken to 0x0200 -> 0x0040 misses (prediction_pc=0x0042) and 0x0060 predicts 0x0200; a not-taken miss at 0x0080 leaves the entry unchanged.
- Squash: branch reaches execute with valid_execute=0 and jump=1 -> no entry allocated. Stall: hold valid_rf_read=0 for 3 cycles with a branch in rf_read -> the update still lands on that branch's PC.
- Same-cycle update and lookup of index 0 -> output reflects old entry that cycle, new entry next cycle. Assert reset during the update edge -> all entries invalid afterwards.
